// File: rtl/pio_pixel_injector_if.sv
// Pixel injector bus bundle.
//
// Groups the HPS-facing PIO words and the pixel stream to the hog core.
//   ctrl_pio   [0] req toggle, [1] soft clear (level), [2] enable, [4:3] nbytes-1
//   data_pio   packed pixels, byte0 = [7:0] emitted first
//   status_pio [0] ack toggle, [1] fifo_empty, [2] fifo_full, [3] busy,
//              [11:4] fifo count, [15:12] 0, [31:16] pixels emitted
//   pix_out / pix_valid / pix_ready : 8-bit pixel stream
//
// Handshake: a pixel transfers on every rising clk edge where pix_valid and
// pix_ready are both 1. Once pix_valid is raised, pix_valid and pix_out stay
// unchanged until that transfer happens. The only exceptions are a soft clear
// and reset, which withdraw the pixel. pix_ready may change on any cycle.
//
// Modports:
//   master : HPS / hog-core side (drives ctrl, data and ready)
//   slave  : injector side (drives status and the pixel stream)
interface pio_pixel_injector_if;
    logic [31:0] ctrl_pio;
    logic [31:0] data_pio;
    logic [31:0] status_pio;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output ctrl_pio,
        output data_pio,
        output pix_ready,
        input  status_pio,
        input  pix_out,
        input  pix_valid
    );

    modport slave (
        input  ctrl_pio,
        input  data_pio,
        input  pix_ready,
        output status_pio,
        output pix_out,
        output pix_valid
    );
endinterface

// File: rtl/pio_pixel_injector.sv
// Pixel injector: turns HPS PIO writes into a valid/ready 8-bit pixel stream.
//
// The HPS writes a packed word to data_pio and then toggles ctrl_pio[0]. Each
// new toggle pushes {data, nbytes-1} into a FIFO and is acknowledged on
// status_pio[0]. A two-state FSM pops words and serialises them LSB byte
// first onto pix_out. Progress is reported on status_pio.
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  pio_pixel_injector_if.slave (ctrl/data/status PIOs and the pixel stream)
//
// Parameters:
//   FIFO_DEPTH  number of buffered words (2..255)
//   CNT_W       width of the emitted-pixel counter (<= 16)
module pio_pixel_injector #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pio_pixel_injector_if.slave   bus
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Control word fields.
    logic       req;
    logic       sclr;
    logic       enable;
    logic [1:0] nbm1;

    assign req    = bus.ctrl_pio[0];
    assign sclr   = bus.ctrl_pio[1];
    assign enable = bus.ctrl_pio[2];
    assign nbm1   = bus.ctrl_pio[4:3];

    logic unused_ctrl;
    assign unused_ctrl = ^bus.ctrl_pio[31:5];

    // Request / acknowledge.
    logic req_prev_q;
    logic ack_q;

    // FIFO of {data, nbytes-1}.
    logic [33:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic [33:0]   rd_word;
    logic          push;
    logic          pop;

    // Serialiser.
    state_t      state_q;
    state_t      state_d;
    logic [31:0] shift_q;
    logic [31:0] shift_d;
    logic [1:0]  rem_q;
    logic [1:0]  rem_d;
    logic        busy;
    logic        xfer;
    logic [CNT_W-1:0] pix_cnt_q;

    // Full/empty come from the registered count, so a word pushed this cycle
    // is only visible to the FSM on the next one.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign rd_word    = mem[rd_ptr_q];

    // A pending toggle is retried every cycle while the FIFO is full; while a
    // soft clear is held, toggles are absorbed without storing anything.
    assign push = (req != req_prev_q) && !fifo_full && !sclr;

    assign busy = (state_q == S_SHIFT);
    assign xfer = busy && bus.pix_ready;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Next-state and serialiser datapath.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && enable) begin
                    pop     = 1'b1;
                    shift_d = rd_word[33:2];
                    rem_d   = rd_word[1:0];
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.pix_ready) begin
                    if (rem_q != 2'd0) begin
                        shift_d = {8'd0, shift_q[31:8]};
                        rem_d   = rem_q - 2'd1;
                    end else if (!fifo_empty && enable) begin
                        // Chain straight into the next word: no idle cycle.
                        pop     = 1'b1;
                        shift_d = rd_word[33:2];
                        rem_d   = rd_word[1:0];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            rem_q   <= '0;
        end else if (sclr) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
        end
    end

    // Request tracking. Under soft clear the ack still follows the request so
    // an HPS waiting on ack==req is never left hanging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev_q <= 1'b0;
            ack_q      <= 1'b0;
        end else if (sclr || push) begin
            req_prev_q <= req;
            ack_q      <= req;
        end
    end

    // FIFO storage has no reset; validity is carried by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.data_pio, nbm1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Emitted-pixel counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_q <= '0;
        end else if (sclr) begin
            pix_cnt_q <= '0;
        end else if (xfer) begin
            pix_cnt_q <= pix_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pix_valid  = busy;
    assign bus.pix_out    = busy ? shift_q[7:0] : 8'd0;
    assign bus.status_pio = {16'(pix_cnt_q), 4'd0, 8'(count_q),
                             busy, fifo_full, fifo_empty, ack_q};

endmodule
